// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one left barrel shifter between two requesters.
// Right shifts reuse the same shifter by bit-reversing the operand and the result.
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [SHW-1:0]   req_shamt_0,
  input  logic             req_op_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [SHW-1:0]   req_shamt_1,
  input  logic             req_op_1,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             gnt_0, gnt_1;
  logic [WIDTH-1:0] shifter_a, shifter_b, shifter_r;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Requester 1 wins only when it is alone or it is its turn; requester 0 takes every other grant.
  assign gnt_1 = req_valid_1 & (~req_valid_0 | rr_ptr_q);
  assign gnt_0 = req_valid_0 & ~gnt_1;

  assign shifter_a = op_q ? bitrev(a_q) : a_q;
  assign shifter_b = {{(WIDTH-SHW){1'b0}}, shamt_q};
  assign shifter_r = shifter_a << shifter_b;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    shamt_d     = shamt_q;
    op_d        = op_q;
    rsp_data_d  = rsp_data_q;
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    rsp_valid_0 = 1'b0;
    rsp_valid_1 = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_0 = gnt_0;
        req_ready_1 = gnt_1;
        if (gnt_0 || gnt_1) begin
          owner_d  = gnt_1;
          rr_ptr_d = ~gnt_1;
          a_d      = gnt_1 ? req_a_1     : req_a_0;
          shamt_d  = gnt_1 ? req_shamt_1 : req_shamt_0;
          op_d     = gnt_1 ? req_op_1    : req_op_0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = op_q ? bitrev(shifter_r) : shifter_r;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid_0 = ~owner_q;
        rsp_valid_1 = owner_q;
        // Only the owning requester's acknowledge can release the result.
        if (owner_q ? rsp_ready_1 : rsp_ready_0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      owner_q    <= 1'b0;
      a_q        <= '0;
      shamt_q    <= '0;
      op_q       <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      a_q        <= a_d;
      shamt_q    <= shamt_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// compared against a plain-arithmetic shift model and a turn-taking grant model.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_0, req_ready_0, req_op_0;
  logic [31:0] req_a_0;
  logic [4:0]  req_shamt_0;
  logic        req_valid_1, req_ready_1, req_op_1;
  logic [31:0] req_a_1;
  logic [4:0]  req_shamt_1;
  logic        rsp_valid_0, rsp_ready_0, rsp_valid_1, rsp_ready_1;
  logic [31:0] rsp_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit pref     = 1'b0;

  logic [31:0] ra0, ra1;
  logic [4:0]  rs0, rs1;
  bit          ro0, ro1, rv0, rv1, rwrong;
  int          rdelay, rmask;

  shift_arbiter #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0),
    .req_shamt_0(req_shamt_0), .req_op_0(req_op_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1),
    .req_shamt_1(req_shamt_1), .req_op_1(req_op_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] refShift(input logic [31:0] a, input logic [4:0] sh, input bit op);
    return op ? (a >> sh) : (a << sh);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input bit v, input logic [31:0] a,
                               input logic [4:0] sh, input bit op);
    if (ch == 0) begin
      req_valid_0 = v; req_a_0 = a; req_shamt_0 = sh; req_op_0 = op;
    end else begin
      req_valid_1 = v; req_a_1 = a; req_shamt_1 = sh; req_op_1 = op;
    end
  endtask

  // One complete transaction; called at a point just after a falling edge.
  task automatic doOp(input bit v0, input bit v1,
                      input logic [31:0] a0, input logic [4:0] s0, input bit o0,
                      input logic [31:0] a1, input logic [4:0] s1, input bit o1,
                      input int ack_delay, input bit wrong_ack, input bit side_valid);
    int          own;
    int          waited;
    logic [31:0] expd;
    applyStimulus(0, v0, a0, s0, o0);
    applyStimulus(1, v1, a1, s1, o1);
    #1;
    own    = (v0 && v1) ? int'(pref) : (v0 ? 0 : 1);
    waited = 0;
    while (!(req_ready_0 || req_ready_1) && waited < 6) begin
      @(negedge clk); #1;
      waited++;
    end
    checkOutput("grant", {30'b0, req_ready_1, req_ready_0}, (own == 1) ? 32'd2 : 32'd1);
    expd = (own == 1) ? refShift(a1, s1, o1) : refShift(a0, s0, o0);

    @(negedge clk);
    pref = (own == 0);
    if (own == 0) begin
      req_valid_0 = 1'b0;
      req_valid_1 = side_valid;
    end else begin
      req_valid_1 = 1'b0;
      req_valid_0 = side_valid;
    end
    #1;
    checkOutput("exec_busy", 32'(busy), 32'd1);
    checkOutput("exec_rsp_valid", {30'b0, rsp_valid_1, rsp_valid_0}, 32'd0);
    checkOutput("exec_req_ready", {30'b0, req_ready_1, req_ready_0}, 32'd0);

    @(negedge clk); #1;
    checkOutput("rsp_valid", {30'b0, rsp_valid_1, rsp_valid_0}, (own == 1) ? 32'd2 : 32'd1);
    checkOutput("rsp_data", rsp_data, expd);

    for (int i = 0; i < ack_delay; i++) begin
      if (own == 0) rsp_ready_1 = wrong_ack;
      else          rsp_ready_0 = wrong_ack;
      @(negedge clk); #1;
      checkOutput("hold_rsp_valid", {30'b0, rsp_valid_1, rsp_valid_0}, (own == 1) ? 32'd2 : 32'd1);
      checkOutput("hold_rsp_data", rsp_data, expd);
      checkOutput("hold_req_ready", {30'b0, req_ready_1, req_ready_0}, 32'd0);
    end

    rsp_ready_0 = (own == 0);
    rsp_ready_1 = (own == 1);
    @(negedge clk);
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_rsp_valid", {30'b0, rsp_valid_1, rsp_valid_0}, 32'd0);
    checkOutput("idle_retain_data", rsp_data, expd);
    checkOutput("side_grant", 32'((own == 0) ? req_ready_1 : req_ready_0), 32'(side_valid));
  endtask

  initial begin
    reset       = 1'b1;
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    applyStimulus(0, 1'b0, 32'd0, 5'd0, 1'b0);
    applyStimulus(1, 1'b0, 32'd0, 5'd0, 1'b0);

    @(negedge clk); #1;
    checkOutput("reset_req_ready", {30'b0, req_ready_1, req_ready_0}, 32'd0);
    checkOutput("reset_rsp_valid", {30'b0, rsp_valid_1, rsp_valid_0}, 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] SLL on requester 0");
    doOp(1, 0, 32'h0000_0001, 5'd31, 1'b0, 32'd0, 5'd0, 1'b0, 0, 0, 0);

    $display("[TB] SRL on requester 1");
    doOp(0, 1, 32'd0, 5'd0, 1'b0, 32'hF000_000F, 5'd4, 1'b1, 1, 0, 0);
    doOp(0, 1, 32'd0, 5'd0, 1'b0, 32'hF000_000F, 5'd0, 1'b1, 0, 0, 0);

    $display("[TB] Arbitration with both requesters valid");
    for (int k = 0; k < 4; k++) begin
      doOp(1, 1, 32'h1, 5'd1, 1'b0, 32'h2, 5'd2, 1'b0, 0, 0, 0);
    end

    $display("[TB] Backpressure on requester 0 with requester 1 waiting");
    doOp(1, 0, 32'hDEAD_BEEF, 5'd8, 1'b1, 32'h1234_5678, 5'd3, 1'b0, 10, 0, 1);
    doOp(0, 1, 32'd0, 5'd0, 1'b0, 32'h1234_5678, 5'd3, 1'b0, 0, 0, 0);

    $display("[TB] Wrong-owner acknowledge");
    doOp(0, 1, 32'd0, 5'd0, 1'b0, 32'hA5A5_0001, 5'd17, 1'b0, 3, 1, 0);

    $display("[TB] Randomized traffic");
    for (int k = 0; k < 24; k++) begin
      rmask  = int'($urandom_range(1, 3));
      rv0    = rmask[0];
      rv1    = rmask[1];
      ra0    = $urandom;
      ra1    = $urandom;
      rs0    = 5'($urandom_range(0, 31));
      rs1    = 5'($urandom_range(0, 31));
      ro0    = 1'($urandom_range(0, 1));
      ro1    = 1'($urandom_range(0, 1));
      rdelay = int'($urandom_range(0, 3));
      rwrong = 1'($urandom_range(0, 1));
      doOp(rv0, rv1, ra0, rs0, ro0, ra1, rs1, ro1, rdelay, rwrong, 0);
    end

    $display("[TB] Reset during EXEC");
    applyStimulus(0, 1'b1, 32'h0000_00FF, 5'd4, 1'b0);
    #1;
    checkOutput("pre_reset_grant", {30'b0, req_ready_1, req_ready_0}, 32'd1);
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'd0, 5'd0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midexec_reset_busy", 32'(busy), 32'd0);
    checkOutput("midexec_reset_rsp_valid", {30'b0, rsp_valid_1, rsp_valid_0}, 32'd0);
    checkOutput("midexec_reset_req_ready", {30'b0, req_ready_1, req_ready_0}, 32'd0);
    checkOutput("midexec_reset_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pref  = 1'b0;
    @(negedge clk); #1;
    checkOutput("post_reset_no_rsp", {30'b0, rsp_valid_1, rsp_valid_0}, 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    doOp(1, 1, 32'h0000_0003, 5'd2, 1'b0, 32'h8000_0000, 5'd31, 1'b1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
